// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and row helpers for the 1R/1W init SRAM
package sram_pkg;

  // Helpers work on a fixed maximum row size; callers slice down to WIDTH.
  localparam int MAX_WIDTH = 2048;
  localparam int MAX_WORDS = 64;

  typedef enum logic [0:0] {INIT = 1'b0, DONE = 1'b1} sram_init_state_e;

  localparam logic [0:0] STATE_INIT = 1'(INIT);
  localparam logic [0:0] STATE_DONE = 1'(DONE);

  function automatic logic [MAX_WIDTH-1:0] fill_row(input logic fill, input int width);
    logic [MAX_WIDTH-1:0] row;
    row = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      if (i < width) row[i] = fill;
    end
    return row;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] merge_words(input logic [MAX_WIDTH-1:0] oldRow,
                                                       input logic [MAX_WIDTH-1:0] newRow,
                                                       input logic [MAX_WORDS-1:0] mask,
                                                       input int wordSize);
    logic [MAX_WIDTH-1:0] row;
    logic [MAX_WORDS-1:0] shifted;
    row = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      shifted = mask >> (i / wordSize);
      row[i] = shifted[0] ? newRow[i] : oldRow[i];
    end
    return row;
  endfunction

endpackage

// File: rtl/sram_init_seq.sv
// rtl/sram_init_seq.sv - init/clear sequencer: walks every row once, then reports ready
module sram_init_seq
  import sram_pkg::*;
#(
  parameter int LOG_NUM_ROWS = 9
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  output logic                    ready,
  output logic                    initWrite,
  output logic [LOG_NUM_ROWS-1:0] initRow
);

  localparam logic [LOG_NUM_ROWS-1:0] LAST_ROW = '1;

  logic [0:0] state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= STATE_INIT;
      initRow <= '0;
    end else if (clear) begin
      state   <= STATE_INIT;
      initRow <= '0;
    end else if (state == STATE_INIT) begin
      // initRow wraps to 0 on the last row, leaving it ready for the next clear.
      initRow <= initRow + 1'b1;
      if (initRow == LAST_ROW) state <= STATE_DONE;
    end
  end

  assign ready     = (state == STATE_DONE);
  assign initWrite = (state == STATE_INIT);

endmodule

// File: rtl/sram_2p_init.sv
// rtl/sram_2p_init.sv - 1R/1W SRAM with sequenced init, soft clear, bypass and read pipe
module sram_2p_init
  import sram_pkg::*;
#(
  parameter int   WIDTH        = 512,
  parameter int   LOG_NUM_ROWS = 9,
  parameter int   WORD_SIZE    = 64,
  parameter int   READ_LATENCY = 1,
  parameter int   BYPASS       = 1,
  parameter logic INIT_FILL    = 1'b1,
  localparam int  NUM_ROWS     = 2 ** LOG_NUM_ROWS,
  localparam int  NUM_WORDS    = WIDTH / WORD_SIZE
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  output logic                    ready,
  input  logic                    readEnable,
  input  logic [LOG_NUM_ROWS-1:0] readAddr,
  output logic [WIDTH-1:0]        readData,
  output logic                    readValid,
  input  logic [LOG_NUM_ROWS-1:0] writeAddr,
  input  logic [WIDTH-1:0]        writeData,
  input  logic [NUM_WORDS-1:0]    writeEnable
);

  if (WIDTH % WORD_SIZE != 0) begin : gBadWordSize
    $fatal(1, "sram_2p_init: WIDTH must be a multiple of WORD_SIZE");
  end
  if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : gBadLatency
    $fatal(1, "sram_2p_init: READ_LATENCY must be 1 or 2");
  end
  if (WIDTH > MAX_WIDTH || NUM_WORDS > MAX_WORDS) begin : gTooWide
    $fatal(1, "sram_2p_init: row exceeds helper capacity");
  end

  logic                    initWrite;
  logic [LOG_NUM_ROWS-1:0] initRow;

  sram_init_seq #(.LOG_NUM_ROWS(LOG_NUM_ROWS)) uInitSeq (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .ready     (ready),
    .initWrite (initWrite),
    .initRow   (initRow)
  );

  logic [WIDTH-1:0] mem [NUM_ROWS];

  logic [MAX_WORDS-1:0] maskWide;
  logic [MAX_WIDTH-1:0] fillWide;
  logic [MAX_WIDTH-1:0] writeMergeWide;
  logic [MAX_WIDTH-1:0] readMergeWide;
  logic [WIDTH-1:0]     readOld;
  logic [WIDTH-1:0]     readRow;
  logic                 userWrite;
  logic                 sameRow;
  logic                 readAccept;
  logic                 unusedWide;

  assign maskWide       = MAX_WORDS'(writeEnable);
  assign fillWide       = fill_row(INIT_FILL, WIDTH);
  assign writeMergeWide = merge_words(MAX_WIDTH'(mem[writeAddr]), MAX_WIDTH'(writeData),
                                      maskWide, WORD_SIZE);
  assign readOld        = mem[readAddr];
  assign readMergeWide  = merge_words(MAX_WIDTH'(readOld), MAX_WIDTH'(writeData),
                                      maskWide, WORD_SIZE);
  assign unusedWide     = ^{fillWide, writeMergeWide, readMergeWide};

  assign userWrite  = ready && (|writeEnable);
  assign readAccept = ready && readEnable;
  assign sameRow    = userWrite && (writeAddr == readAddr);
  assign readRow    = (BYPASS != 0 && sameRow) ? readMergeWide[WIDTH-1:0] : readOld;

  // The init write owns the array while not ready; user writes only land in DONE.
  always_ff @(posedge clk) begin
    if (initWrite) mem[initRow] <= fillWide[WIDTH-1:0];
    else if (userWrite) mem[writeAddr] <= writeMergeWide[WIDTH-1:0];
  end

  logic             valid1;
  logic [WIDTH-1:0] data1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid1 <= 1'b0;
      data1  <= '0;
    end else begin
      valid1 <= readAccept;
      if (readAccept) data1 <= readRow;
    end
  end

  if (READ_LATENCY == 2) begin : gLat2
    logic             valid2;
    logic [WIDTH-1:0] data2;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        valid2 <= 1'b0;
        data2  <= '0;
      end else begin
        valid2 <= valid1;
        if (valid1) data2 <= data1;
      end
    end

    assign readValid = valid2;
    assign readData  = data2;
  end else begin : gLat1
    assign readValid = valid1;
    assign readData  = data1;
  end

endmodule

// File: tb/tb_sram_2p_init.sv
// tb/tb_sram_2p_init.sv - directed bench for sram_2p_init (lat1/bypass and lat2/no-bypass)
module tb_sram_2p_init;

  localparam logic [511:0] ONES = '1;

  logic         clk = 1'b0;
  logic         reset;
  logic         clear;
  logic         readEnable;
  logic [8:0]   readAddr;
  logic [8:0]   writeAddr;
  logic [511:0] writeData;
  logic [7:0]   writeEnable;

  logic         ready1, readValid1, ready2, readValid2;
  logic [511:0] readData1, readData2;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  sram_2p_init dut1 (
    .clk(clk), .reset(reset), .clear(clear), .ready(ready1),
    .readEnable(readEnable), .readAddr(readAddr), .readData(readData1), .readValid(readValid1),
    .writeAddr(writeAddr), .writeData(writeData), .writeEnable(writeEnable)
  );

  sram_2p_init #(.READ_LATENCY(2), .BYPASS(0)) dut2 (
    .clk(clk), .reset(reset), .clear(clear), .ready(ready2),
    .readEnable(readEnable), .readAddr(readAddr), .readData(readData2), .readValid(readValid2),
    .writeAddr(writeAddr), .writeData(writeData), .writeEnable(writeEnable)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic waitReady(output int cycles);
    cycles = 0;
    while (ready1 !== 1'b1 && cycles < 2000) begin
      tick();
      cycles++;
    end
  endtask

  function automatic logic [511:0] pattern(input logic [31:0] seed);
    logic [511:0] p;
    for (int w = 0; w < 8; w++) p[w*64 +: 64] = {seed, 32'(w)};
    return p;
  endfunction

  initial begin
    int           cycles;
    int           bad1;
    int           bad2;
    logic [511:0] patA, patD, patN, exp3, merged;

    patA = pattern(32'hA5A5_0001);
    patD = pattern(32'hD00D_0003);
    patN = pattern(32'h0BAD_0004);
    exp3 = ONES;
    exp3[63:0] = patD[63:0];
    merged = ONES;
    merged[255:0] = patN[255:0];

    reset = 1'b1; clear = 1'b0; readEnable = 1'b0; readAddr = '0;
    writeAddr = '0; writeData = '0; writeEnable = '0;
    repeat (3) tick();
    check("rst_ready", 512'(ready1), 512'(0));
    check("rst_valid1", 512'(readValid1), 512'(0));
    check("rst_data1", readData1, '0);
    check("rst_valid2", 512'(readValid2), 512'(0));
    check("rst_data2", readData2, '0);

    // 1: init length and contents, back-to-back reads
    reset = 1'b0;
    waitReady(cycles);
    check("init_cycles", 512'(cycles), 512'(512));
    check("init_ready2", 512'(ready2), 512'(1));
    bad1 = 0; bad2 = 0;
    for (int r = 0; r <= 512; r++) begin
      if (r < 512) begin
        readEnable = 1'b1;
        readAddr = 9'(r);
      end else begin
        readEnable = 1'b0;
      end
      tick();
      if (r < 512 && !(readValid1 === 1'b1 && readData1 === ONES)) bad1++;
      if (r > 0 && !(readValid2 === 1'b1 && readData2 === ONES)) bad2++;
    end
    check("init_rows_lat1", 512'(bad1), 512'(0));
    check("init_rows_lat2", 512'(bad2), 512'(0));
    check("valid1_pulse_end", 512'(readValid1), 512'(0));

    // 2: full-row write then read
    writeAddr = 9'd5; writeData = patA; writeEnable = 8'hFF;
    tick();
    writeEnable = 8'h00; readEnable = 1'b1; readAddr = 9'd5;
    tick();
    readEnable = 1'b0;
    check("t2_valid1", 512'(readValid1), 512'(1));
    check("t2_data1", readData1, patA);
    check("t2_valid2_early", 512'(readValid2), 512'(0));
    tick();
    check("t2_valid2", 512'(readValid2), 512'(1));
    check("t2_data2", readData2, patA);
    check("t2_valid1_drop", 512'(readValid1), 512'(0));
    check("t2_data1_hold", readData1, patA);

    // 3: single-word write
    writeAddr = 9'd7; writeData = patD; writeEnable = 8'h01;
    tick();
    writeEnable = 8'h00; readEnable = 1'b1; readAddr = 9'd7;
    tick();
    readEnable = 1'b0;
    check("t3_data1", readData1, exp3);
    tick();
    check("t3_data2", readData2, exp3);

    // 4: read-during-write same row, then a different-row pair
    writeAddr = 9'd9; writeData = patN; writeEnable = 8'h0F;
    readEnable = 1'b1; readAddr = 9'd9;
    tick();
    writeEnable = 8'h00; readEnable = 1'b0;
    check("t4_bypass_data1", readData1, merged);
    tick();
    check("t4_nobypass_data2", readData2, ONES);
    readEnable = 1'b1; readAddr = 9'd9;
    tick();
    readEnable = 1'b0;
    check("t4_later_data1", readData1, merged);
    tick();
    check("t4_later_data2", readData2, merged);
    writeAddr = 9'd10; writeData = patN; writeEnable = 8'hFF;
    readEnable = 1'b1; readAddr = 9'd11;
    tick();
    writeEnable = 8'h00; readAddr = 9'd10;
    check("t4_indep_data1", readData1, ONES);
    tick();
    readEnable = 1'b0;
    check("t4_row10_data1", readData1, patN);
    check("t4_indep_data2", readData2, ONES);
    tick();
    check("t4_row10_data2", readData2, patN);

    // 5: soft clear with a read in flight; writes and reads ignored during init
    repeat (60) tick();
    clear = 1'b1; readEnable = 1'b1; readAddr = 9'd7;
    tick();
    clear = 1'b0; readAddr = 9'd5;
    check("t5_ready_drop", 512'(ready1), 512'(0));
    check("t5_inflight_valid1", 512'(readValid1), 512'(1));
    check("t5_inflight_data1", readData1, exp3);
    tick();
    readEnable = 1'b0;
    check("t5_ignored_valid1", 512'(readValid1), 512'(0));
    check("t5_inflight_valid2", 512'(readValid2), 512'(1));
    check("t5_inflight_data2", readData2, exp3);
    repeat (8) tick();
    writeAddr = 9'd3; writeData = patA; writeEnable = 8'hFF;
    tick();
    writeEnable = 8'h00;
    waitReady(cycles);
    check("t5_init_cycles", 512'(cycles + 10), 512'(512));
    readEnable = 1'b1; readAddr = 9'd3;
    tick();
    readAddr = 9'd5;
    check("t5_row3", readData1, ONES);
    tick();
    readEnable = 1'b0;
    check("t5_row5_reinit", readData1, ONES);

    // 6: async reset at initRow 200, then full init; async reset while a read is valid
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (200) tick();
    #2 reset = 1'b1;
    #1;
    check("t6_ready_async", 512'(ready1), 512'(0));
    check("t6_valid_async", 512'(readValid1), 512'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    waitReady(cycles);
    check("t6_init_cycles", 512'(cycles), 512'(512));
    readEnable = 1'b1; readAddr = 9'd9;
    tick();
    readEnable = 1'b0;
    check("t6_valid1", 512'(readValid1), 512'(1));
    check("t6_row9", readData1, ONES);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_valid1", 512'(readValid1), 512'(0));
    check("t6_rst_data1", readData1, '0);
    check("t6_rst_valid2", 512'(readValid2), 512'(0));
    check("t6_rst_ready", 512'(ready1), 512'(0));
    tick();
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
